reg_scoreboard: RTL and testbench

//  Tracks in-flight writes to the 16-entry register file and sequences ID-stage issue around them.
//  - Sits beside the register file in the ID stage.
//  - Each issued instruction with writeback reserves its destination register.
//  - The WB-stage writeBackEn/dest_wb pair releases that reservation.
//  - Read-after-write hazards raise a stall, so the ID stage never reads a stale operand.

---
 rtl/reg_scoreboard_pkg.sv | 23 ++
 rtl/reg_scoreboard_if.sv | 33 +++
 rtl/reg_scoreboard_sb_counter.sv | 39 +++
 rtl/reg_scoreboard.sv | 81 ++++++++
 tb/tb_reg_scoreboard.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the register-file write scoreboard.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package reg_scoreboard_pkg;

  // Register-file geometry, shared with the rest of the ID stage.
  localparam int REG_ADDRESS_LEN   = 4;
  localparam int REGISTER_MEM_SIZE = 16;
  localparam int SB_CNT_LEN        = 2;

  localparam int NUM_REGS = REGISTER_MEM_SIZE;
  localparam int ADDR_W   = REG_ADDRESS_LEN;
  localparam int CNT_W    = SB_CNT_LEN;
  localparam int INFL_W   = CNT_W + ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0]  sb_cnt_t;
  typedef logic [INFL_W-1:0] sb_infl_t;

  localparam sb_cnt_t CNT_MAX = {CNT_W{1'b1}};
  localparam sb_cnt_t CNT_ONE = sb_cnt_t'(1);

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue/retire bundle between the ID/WB stages and the scoreboard.
// Latency: n/a (wiring only); stall is combinational on the issue fields.
// Backpressure: stall holds the ID stage; retire is never backpressured.
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;

  logic                issue_valid;
  logic                issue_wb_en;
  reg_addr_t           issue_dest;
  reg_addr_t           src1;
  reg_addr_t           src2;
  logic                src2_used;
  logic                flush;
  logic                retire_valid;
  reg_addr_t           retire_dest;
  logic                stall;
  logic [NUM_REGS-1:0] pending_mask;
  sb_infl_t            inflight;
  logic                err_underflow;

  modport master (
    output issue_valid, issue_wb_en, issue_dest, src1, src2, src2_used, flush,
    output retire_valid, retire_dest,
    input  stall, pending_mask, inflight, err_underflow
  );

  modport slave (
    input  issue_valid, issue_wb_en, issue_dest, src1, src2, src2_used, flush,
    input  retire_valid, retire_dest,
    output stall, pending_mask, inflight, err_underflow
  );

endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// One per-register pending-write counter, saturating at both ends.
// Latency: count changes one cycle after inc/dec; flags derive from the register.
// Backpressure: none; the caller must not increment at max (stall prevents it).
module sb_counter
  import reg_scoreboard_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    inc,
  input  logic    dec,
  output sb_cnt_t cnt,
  output logic    nonzero,
  output logic    at_max
);

  sb_cnt_t cnt_q;
  logic    inc_eff;
  logic    dec_eff;

  // Never wrap: ignore an increment at max and a decrement at zero.
  assign inc_eff = inc && !at_max;
  assign dec_eff = dec && nonzero;

  // Counter register; simultaneous inc and dec cancel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (inc_eff && !dec_eff) begin
      cnt_q <= cnt_q + CNT_ONE;
    end else if (dec_eff && !inc_eff) begin
      cnt_q <= cnt_q - CNT_ONE;
    end
  end

  assign cnt     = cnt_q;
  assign nonzero = (cnt_q != '0);
  assign at_max  = (cnt_q == CNT_MAX);

endmodule

// File: rtl/reg_scoreboard.sv
// Tracks outstanding register writes and stalls ID on read-after-write hazards.
// Latency: stall is same-cycle; reservations show in pending_mask one cycle after accept.
// Backpressure: stall=1 means the presented instruction is not accepted and must be held.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  reg_scoreboard_if.slave   sb
);

  sb_cnt_t             cnt [NUM_REGS];
  logic [NUM_REGS-1:0] nonzero;
  logic [NUM_REGS-1:0] at_max;
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;
  logic [NUM_REGS-1:0] hz;
  logic                stall_c;
  logic                accept;
  logic                retire_ok;
  logic                retire_underflow;
  sb_infl_t            inflight_q;
  logic                err_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    assign inc[i] = accept && (sb.issue_dest == ADDR_W'(i));
    assign dec[i] = sb.retire_valid && (sb.retire_dest == ADDR_W'(i));
    // A last write retiring now lands in the RF on negedge, so ID can read it this cycle.
    assign hz[i]  = nonzero[i] && !(dec[i] && (cnt[i] == CNT_ONE));

    sb_counter u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc[i]),
      .dec     (dec[i]),
      .cnt     (cnt[i]),
      .nonzero (nonzero[i]),
      .at_max  (at_max[i])
    );
  end

  // Stall on source hazards or a saturated destination (same-cycle retire not credited).
  always_comb begin
    stall_c = 1'b0;
    if (sb.issue_valid && !sb.flush) begin
      stall_c = hz[sb.src1]
              || (sb.src2_used && hz[sb.src2])
              || (sb.issue_wb_en && at_max[sb.issue_dest]);
    end
  end

  assign accept           = sb.issue_valid && !sb.flush && !stall_c && sb.issue_wb_en;
  assign retire_ok        = sb.retire_valid && nonzero[sb.retire_dest];
  assign retire_underflow = sb.retire_valid && !nonzero[sb.retire_dest];

  // Running total of all counters, using the same gated +1/-1 as the counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= '0;
    end else if (accept && !retire_ok) begin
      inflight_q <= inflight_q + sb_infl_t'(1);
    end else if (retire_ok && !accept) begin
      inflight_q <= inflight_q - sb_infl_t'(1);
    end
  end

  // Sticky flag for a retire with nothing outstanding; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (retire_underflow) begin
      err_q <= 1'b1;
    end
  end

  assign sb.stall         = stall_c;
  assign sb.pending_mask  = nonzero;
  assign sb.inflight      = inflight_q;
  assign sb.err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios then random traffic vs a counter-array model.
// Latency: inputs driven after negedge, stall sampled #1 later, state sampled #1 after posedge.
// Backpressure: model decides acceptance from its own counts each cycle.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_scoreboard_if sb_if ();

  reg_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if.slave)
  );

  int tests = 0;
  int fails = 0;
  int cnt_m [NUM_REGS];
  bit err_m;
  bit last_stall;

  // Reference rules written directly from the hazard definition.
  function automatic bit hz_m(int r);
    return (cnt_m[r] != 0) &&
           !(sb_if.retire_valid && int'(sb_if.retire_dest) == r && cnt_m[r] == 1);
  endfunction

  function automatic bit stall_m();
    if (!sb_if.issue_valid || sb_if.flush) return 1'b0;
    return hz_m(int'(sb_if.src1)) ||
           (sb_if.src2_used && hz_m(int'(sb_if.src2))) ||
           (sb_if.issue_wb_en && cnt_m[int'(sb_if.issue_dest)] == 3);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_REGS; i++) cnt_m[i] = 0;
    err_m = 1'b0;
  endtask

  task automatic check_bit(string tag, logic got, logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0b exp=%0b", tag, got, exp);
    end
  endtask

  task automatic check_state(string tag);
    logic [NUM_REGS-1:0] mask_e;
    int sum;
    sum = 0;
    for (int i = 0; i < NUM_REGS; i++) begin
      mask_e[i] = (cnt_m[i] != 0);
      sum += cnt_m[i];
    end
    tests++;
    assert (sb_if.pending_mask === mask_e) else begin
      fails++;
      $error("FAIL %s pending_mask got=%h exp=%h", tag, sb_if.pending_mask, mask_e);
    end
    tests++;
    assert (sb_if.inflight === INFL_W'(sum)) else begin
      fails++;
      $error("FAIL %s inflight got=%0d exp=%0d", tag, sb_if.inflight, sum);
    end
    check_bit({tag, " err_underflow"}, sb_if.err_underflow, err_m);
  endtask

  // One clock cycle: drive, check stall, clock, update model, check state.
  task automatic step(string tag, bit iv, bit wb, int dest, int s1, int s2, bit s2u,
                      bit fl, bit rv, int rd);
    bit exp_stall;
    bit acc;
    @(negedge clk);
    sb_if.issue_valid  = iv;
    sb_if.issue_wb_en  = wb;
    sb_if.issue_dest   = ADDR_W'(dest);
    sb_if.src1         = ADDR_W'(s1);
    sb_if.src2         = ADDR_W'(s2);
    sb_if.src2_used    = s2u;
    sb_if.flush        = fl;
    sb_if.retire_valid = rv;
    sb_if.retire_dest  = ADDR_W'(rd);
    #1;
    exp_stall  = stall_m();
    last_stall = sb_if.stall;
    check_bit({tag, " stall"}, sb_if.stall, exp_stall);
    acc = iv && !fl && !exp_stall && wb;
    @(posedge clk);
    if (rv) begin
      if (cnt_m[rd] > 0) cnt_m[rd]--;
      else err_m = 1'b1;
    end
    if (acc) cnt_m[dest]++;
    #1;
    check_state(tag);
  endtask

  task automatic idle(string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic async_reset(string tag);
    @(negedge clk);
    #2;
    rst = 1'b0;
    sb_if.issue_valid  = 1'b0;
    sb_if.retire_valid = 1'b0;
    #1;
    model_clear();
    check_state(tag);
    check_bit({tag, " stall"}, sb_if.stall, 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int q[$];
    int rd;
    bit rv;
    model_clear();
    rst = 1'b0;
    sb_if.issue_valid  = 1'b0;
    sb_if.issue_wb_en  = 1'b0;
    sb_if.issue_dest   = '0;
    sb_if.src1         = '0;
    sb_if.src2         = '0;
    sb_if.src2_used    = 1'b0;
    sb_if.flush        = 1'b0;
    sb_if.retire_valid = 1'b0;
    sb_if.retire_dest  = '0;
    #12;
    check_state("reset");
    check_bit("reset stall", sb_if.stall, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Mid-run reset with cnt[3]=2.
    step("r3a", 1, 1, 3, 0, 0, 0, 0, 0, 0);
    step("r3b", 1, 1, 3, 0, 0, 0, 0, 0, 0);
    check_bit("cnt3 pending", sb_if.pending_mask[3], 1'b1);
    async_reset("midreset");

    // RAW on R2: stalls until the retire cycle, which is bypassed.
    step("raw_issue", 1, 1, 2, 0, 0, 0, 0, 0, 0);
    step("raw_hold1", 1, 0, 0, 2, 0, 0, 0, 0, 0);
    check_bit("raw stall1", last_stall, 1'b1);
    step("raw_hold2", 1, 0, 0, 2, 0, 0, 0, 0, 0);
    check_bit("raw stall2", last_stall, 1'b1);
    step("raw_bypass", 1, 0, 0, 2, 0, 0, 0, 1, 2);
    check_bit("raw bypass stall", last_stall, 1'b0);
    check_bit("raw cnt2 zero", sb_if.pending_mask[2], 1'b0);

    // Same-cycle accept and retire on R5.
    step("sc_fill", 1, 1, 5, 0, 0, 0, 0, 0, 0);
    step("sc_both", 1, 1, 5, 0, 0, 0, 0, 1, 5);
    check_bit("sc cnt5 kept", sb_if.pending_mask[5], 1'b1);

    // Saturation on R7.
    step("sat1", 1, 1, 7, 0, 0, 0, 0, 0, 0);
    step("sat2", 1, 1, 7, 0, 0, 0, 0, 0, 0);
    step("sat3", 1, 1, 7, 0, 0, 0, 0, 0, 0);
    step("sat4_stall", 1, 1, 7, 0, 0, 0, 0, 0, 0);
    check_bit("sat 4th stalls", last_stall, 1'b1);
    step("sat_retire", 0, 0, 0, 0, 0, 0, 0, 1, 7);
    step("sat4_ok", 1, 1, 7, 0, 0, 0, 0, 0, 0);
    check_bit("sat 4th accepted", last_stall, 1'b0);

    // Flush suppresses acceptance; src2_used gates the src2 check.
    step("flush", 1, 1, 1, 0, 0, 0, 1, 0, 0);
    check_bit("flush cnt1 zero", sb_if.pending_mask[1], 1'b0);
    step("r4_fill", 1, 1, 4, 0, 0, 0, 0, 0, 0);
    step("src2_imm", 1, 0, 0, 0, 4, 0, 0, 0, 0);
    check_bit("src2 unused", last_stall, 1'b0);
    step("src2_used", 1, 0, 0, 0, 4, 1, 0, 0, 0);
    check_bit("src2 used", last_stall, 1'b1);

    // Underflow on R9 is sticky.
    step("uf", 0, 0, 0, 0, 0, 0, 0, 1, 9);
    check_bit("uf set", sb_if.err_underflow, 1'b1);
    idle("uf_hold");
    check_bit("uf sticky", sb_if.err_underflow, 1'b1);

    // Random traffic, mostly retiring registers that really are pending.
    async_reset("pre_random");
    for (int n = 0; n < 400; n++) begin
      q.delete();
      for (int i = 0; i < NUM_REGS; i++) if (cnt_m[i] != 0) q.push_back(i);
      rv = ($urandom_range(0, 2) == 0);
      rd = int'($urandom_range(0, 7));
      if (rv && q.size() > 0 && $urandom_range(0, 15) != 0)
        rd = q[$urandom_range(0, q.size() - 1)];
      step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 9) == 0), rv, rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
